// File: rtl/clock_period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_period_meter_pkg
// Purpose  : Shared constants for the slow-clock period meter: FSM state
//            encoding and the nominal reference/tick frequencies.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package clock_period_meter_pkg;

    // FSM state encoding
    localparam logic [0:0] WAIT_FIRST = 1'b0;  // waiting for an arming edge
    localparam logic [0:0] MEASURE    = 1'b1;  // counting between rising edges

    // Nominal clocking of the system tick being monitored
    localparam int unsigned CLK_REF_HZ = 12000000;
    localparam int unsigned TICK_HZ    = 1000;
    localparam int unsigned EXPECT     = CLK_REF_HZ / TICK_HZ;

endpackage : clock_period_meter_pkg
`default_nettype wire

// File: rtl/clock_period_meter_sync_edge_rise.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_rise
// Purpose  : Two-flop synchroniser for an asynchronous input followed by a
//            delay flop, producing a single-cycle rising-edge strobe.
// Ports    : clock_in - sampling clock
//            nReset   - asynchronous active-low reset
//            d        - asynchronous input
//            rise     - high for one clock_in cycle per synchronised 0->1
// Revision : 1.0  initial release
// ============================================================================
module sync_edge_rise (
    input  logic clock_in,
    input  logic nReset,
    input  logic d,
    output logic rise
);

    // sync_q[0] = s0, sync_q[1] = s1 (first metastability-safe stage),
    // sync_q[2] = s2 (one-cycle delayed copy of s1 for edge detection)
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d};
    end

    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule : sync_edge_rise
`default_nettype wire

// File: rtl/clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : clock_period_meter
// Purpose  : Measures the period of a slow asynchronous clock in cycles of
//            clock_in, flags whether it is inside EXPECT +/- TOL, and flags a
//            stall when no rising edge arrives within TIMEOUT cycles.
// Ports    : clock_in     - reference clock
//            nReset       - asynchronous active-low reset
//            slow_in      - clock under measurement (asynchronous)
//            period       - last completed period, clock_in cycles
//            period_valid - one-cycle pulse when period updates
//            in_range     - last period within the tolerance window
//            stalled      - no rising edge for TIMEOUT cycles
// Revision : 1.0  initial release
// ============================================================================
module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned EXPECT  = clock_period_meter_pkg::EXPECT,
    parameter int unsigned TOL     = 60,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clock_in,
    input  logic             nReset,
    input  logic             slow_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_range,
    output logic             stalled
);

    // Window bounds; the lower bound clamps at zero instead of wrapping
    localparam logic [CNT_W-1:0] c_win_lo  = CNT_W'((EXPECT > TOL) ? (EXPECT - TOL) : 0);
    localparam logic [CNT_W-1:0] c_win_hi  = CNT_W'(EXPECT + TOL);
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

    logic             w_rise;
    logic             w_in_window;

    logic [0:0]       state_q,    state_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [CNT_W-1:0] period_q,   period_d;
    logic             valid_q,    valid_d;
    logic             in_range_q, in_range_d;
    logic             stalled_q,  stalled_d;

    sync_edge_rise u_sync_edge_rise (
        .clock_in (clock_in),
        .nReset   (nReset),
        .d        (slow_in),
        .rise     (w_rise)
    );

    // count_q is the number of cycles since the previous rise, i.e. the
    // period being captured when w_rise is high in this cycle
    assign w_in_window = (count_q >= c_win_lo) && (count_q <= c_win_hi);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        stalled_d  = stalled_q;

        if (state_q == WAIT_FIRST) begin
            count_d = '0;
            if (w_rise) begin
                // First edge only arms the measurement
                count_d   = CNT_W'(1);
                state_d   = MEASURE;
                stalled_d = 1'b0;
            end
        end else begin
            if (w_rise) begin
                // An edge coinciding with the timeout still yields a period
                period_d   = count_q;
                valid_d    = 1'b1;
                in_range_d = w_in_window;
                count_d    = CNT_W'(1);
            end else if (count_q >= c_timeout) begin
                // Partial count is discarded; next edge re-arms
                stalled_d  = 1'b1;
                in_range_d = 1'b0;
                count_d    = '0;
                state_d    = WAIT_FIRST;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            state_q    <= WAIT_FIRST;
            count_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            stalled_q  <= stalled_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign in_range     = in_range_q;
    assign stalled      = stalled_q;

endmodule : clock_period_meter
`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_period_meter
// Purpose  : Self-checking bench. Three meter instances share one slow_in:
//            inst0 uses the default 12 MHz / 1 kHz setup, inst1 a scaled
//            600-cycle setup, inst2 the scaled setup with TIMEOUT equal to
//            the nominal period. A cycle-level behavioural model predicts
//            every output of every instance each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_clock_period_meter;

    localparam int N = 3;

    logic        clock_in = 1'b0;
    logic        nReset   = 1'b0;
    logic        slow_in  = 1'b0;
    logic [15:0] period_o [N];
    logic        valid_o  [N];
    logic        inr_o    [N];
    logic        stall_o  [N];

    always #5 clock_in = ~clock_in;

    clock_period_meter #(.CNT_W(16), .EXPECT(12000), .TOL(60), .TIMEOUT(65535)) dut_a (
        .clock_in(clock_in), .nReset(nReset), .slow_in(slow_in),
        .period(period_o[0]), .period_valid(valid_o[0]),
        .in_range(inr_o[0]), .stalled(stall_o[0]));

    clock_period_meter #(.CNT_W(16), .EXPECT(600), .TOL(30), .TIMEOUT(1000)) dut_b (
        .clock_in(clock_in), .nReset(nReset), .slow_in(slow_in),
        .period(period_o[1]), .period_valid(valid_o[1]),
        .in_range(inr_o[1]), .stalled(stall_o[1]));

    clock_period_meter #(.CNT_W(16), .EXPECT(600), .TOL(30), .TIMEOUT(600)) dut_c (
        .clock_in(clock_in), .nReset(nReset), .slow_in(slow_in),
        .period(period_o[2]), .period_valid(valid_o[2]),
        .in_range(inr_o[2]), .stalled(stall_o[2]));

    function automatic int exp_of(input int k);
        return (k == 0) ? 12000 : 600;
    endfunction
    function automatic int tol_of(input int k);
        return (k == 0) ? 60 : 30;
    endfunction
    function automatic int to_of(input int k);
        return (k == 0) ? 65535 : ((k == 1) ? 1000 : 600);
    endfunction
    function automatic bit in_win(input int k, input int p);
        int d;
        d = p - exp_of(k);
        if (d < 0) d = -d;
        return d <= tol_of(k);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: edge-indexed. slow_in is sampled at every edge;
    // a rising transition seen in samples j-3 -> j-2 acts at edge j.
    // Period = difference of edge indices between consecutive acting rises.
    // ------------------------------------------------------------------
    int j_cnt = 0;
    bit h0, h1, h2, h3;
    int last  [N];
    bit armed [N];
    int m_per [N];
    bit m_val [N];
    bit m_inr [N];
    bit m_stl [N];

    always @(posedge clock_in) begin
        if (!nReset) begin
            h0 = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            for (int k = 0; k < N; k++) begin
                armed[k] = 1'b0; m_per[k] = 0; m_val[k] = 1'b0;
                m_inr[k] = 1'b0; m_stl[k] = 1'b0; last[k] = 0;
            end
        end else begin
            h3 = h2; h2 = h1; h1 = h0; h0 = slow_in;
            for (int k = 0; k < N; k++) begin
                m_val[k] = 1'b0;
                if (h2 && !h3) begin
                    if (armed[k]) begin
                        m_per[k] = j_cnt - last[k];
                        m_val[k] = 1'b1;
                        m_inr[k] = in_win(k, m_per[k]);
                    end else begin
                        armed[k] = 1'b1;
                        m_stl[k] = 1'b0;
                    end
                    last[k] = j_cnt;
                end else if (armed[k] && (j_cnt - last[k] == to_of(k))) begin
                    m_stl[k] = 1'b1;
                    m_inr[k] = 1'b0;
                    armed[k] = 1'b0;
                end
            end
        end
        j_cnt++;
    end

    // ------------------------------------------------------------------
    // Compare process: model vs DUT every cycle, plus literal spot checks
    // requested by the stimulus process through chk_seq/chk_id.
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int chk_seq = 0;
    int chk_id  = 0;
    int seen    = 0;
    int logp_a[$];
    bit logi_a[$];
    int logp_b[$];
    bit logi_b[$];

    task automatic lit(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic lit_checks(input int id);
        int ep[4];
        bit ei[4];
        int sz;
        case (id)
            2: begin
                lit("square_b_period", int'(period_o[1]), 600);
                lit("square_b_in_range", int'(inr_o[1]), 1);
                lit("timeout_tie_c_period", int'(period_o[2]), 600);
                lit("timeout_tie_c_stalled", int'(stall_o[2]), 0);
            end
            3: begin
                ep = '{570, 630, 569, 631};
                ei = '{1'b1, 1'b1, 1'b0, 1'b0};
                sz = logp_b.size();
                lit("edge_log_size_ok", int'(sz >= 4), 1);
                if (sz >= 4) begin
                    for (int i = 0; i < 4; i++) begin
                        lit($sformatf("edge_period_%0d", ep[i]), logp_b[sz-4+i], ep[i]);
                        lit($sformatf("edge_in_range_%0d", ep[i]), int'(logi_b[sz-4+i]), int'(ei[i]));
                    end
                end
            end
            4: begin
                lit("stall_b_stalled", int'(stall_o[1]), 1);
                lit("stall_b_in_range", int'(inr_o[1]), 0);
                lit("stall_b_valid", int'(valid_o[1]), 0);
            end
            5: begin
                for (int k = 0; k < N; k++) begin
                    lit($sformatf("reset_period_%0d", k), int'(period_o[k]), 0);
                    lit($sformatf("reset_in_range_%0d", k), int'(inr_o[k]), 0);
                    lit($sformatf("reset_stalled_%0d", k), int'(stall_o[k]), 0);
                end
            end
            6: begin
                sz = logp_b.size();
                lit("glitch_log_size_ok", int'(sz >= 2), 1);
                if (sz >= 2) begin
                    lit("glitch_period_first", logp_b[sz-2], 450);
                    lit("glitch_period_second", logp_b[sz-1], 150);
                    lit("glitch_in_range_first", int'(logi_b[sz-2]), 0);
                    lit("glitch_in_range_second", int'(logi_b[sz-1]), 0);
                end
            end
            7: begin
                sz = logp_a.size();
                lit("full_log_size_ok", int'(sz >= 3), 1);
                if (sz >= 3) begin
                    lit("full_period_12000", logp_a[sz-3], 12000);
                    lit("full_in_range_12000", int'(logi_a[sz-3]), 1);
                    lit("full_period_11940", logp_a[sz-2], 11940);
                    lit("full_in_range_11940", int'(logi_a[sz-2]), 1);
                    lit("full_period_12061", logp_a[sz-1], 12061);
                    lit("full_in_range_12061", int'(logi_a[sz-1]), 0);
                end
            end
            default: ;
        endcase
    endtask

    always @(negedge clock_in) begin
        for (int k = 0; k < N; k++) begin
            int wp;
            bit wv, wi, ws;
            if (!nReset) begin
                wp = 0; wv = 1'b0; wi = 1'b0; ws = 1'b0;
            end else begin
                wp = m_per[k]; wv = m_val[k]; wi = m_inr[k]; ws = m_stl[k];
            end
            n_tests++;
            if (period_o[k] != 16'(wp) || valid_o[k] != wv || inr_o[k] != wi || stall_o[k] != ws) begin
                n_fail++;
                $display("FAIL cycle_inst%0d @%0t: got period=%0d valid=%0d in_range=%0d stalled=%0d, want period=%0d valid=%0d in_range=%0d stalled=%0d",
                         k, $time, period_o[k], valid_o[k], inr_o[k], stall_o[k], wp, wv, wi, ws);
            end
        end
        if (nReset && valid_o[0]) begin
            logp_a.push_back(int'(period_o[0]));
            logi_a.push_back(inr_o[0]);
        end
        if (nReset && valid_o[1]) begin
            logp_b.push_back(int'(period_o[1]));
            logi_b.push_back(inr_o[1]);
        end
        if (chk_seq != seen) begin
            seen = chk_seq;
            lit_checks(chk_id);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after the rising edge
    // ------------------------------------------------------------------
    task automatic hold(input logic v, input int n);
        slow_in = v;
        repeat (n) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic wave(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    task automatic trig(input int id);
        chk_id = id;
        chk_seq++;
    endtask

    initial begin
        repeat (5) @(posedge clock_in);
        #1;
        nReset = 1'b1;
        hold(1'b0, 20);

        // Nominal square wave (scaled)
        repeat (5) wave(300, 300);

        // Window edges: 570, 630, 569, 631
        hold(1'b1, 285); trig(2); hold(1'b0, 285);
        wave(315, 315);
        wave(284, 285);
        wave(315, 316);
        hold(1'b1, 300); trig(3); hold(1'b0, 300);

        // Randomised periods around nominal
        repeat (10) wave(int'($urandom_range(350, 250)), int'($urandom_range(350, 250)));

        // Stall, then restart
        hold(1'b1, 300);
        hold(1'b0, 1500);
        trig(4);
        repeat (3) wave(300, 300);

        // Reset in the middle of a measurement
        hold(1'b1, 150);
        nReset = 1'b0;
        trig(5);
        hold(1'b1, 5);
        nReset = 1'b1;
        hold(1'b1, 145);
        hold(1'b0, 300);
        repeat (3) wave(300, 300);

        // Two-cycle glitch splitting a period into 450 + 150
        hold(1'b1, 300);
        hold(1'b0, 150);
        hold(1'b1, 2);
        hold(1'b0, 148);
        hold(1'b1, 300); trig(6); hold(1'b0, 300);

        // Full-scale periods: 12000, 11940, 12061
        wave(6000, 6000);
        wave(5970, 5970);
        wave(6030, 6031);
        hold(1'b1, 100);
        trig(7);
        hold(1'b0, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_clock_period_meter
`default_nettype wire
